// File: rtl/packet_scheduler.sv
// rtl/packet_scheduler.sv - Priority packet scheduler driving reward packing and MAC handoff
module packet_scheduler #(
    parameter int WORD_WIDTH   = 16,
    parameter int MR_TIMEOUT   = 15,
    parameter int CHT_TIMEOUT  = 15,
    parameter int MAX_INV_HOPS = 4,
    parameter int DONE_LIMIT   = 63
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic [2:0]            fPacketType,
    input  logic                  iAmDestination,
    input  logic [WORD_WIDTH-1:0] hopsFromCH,
    input  logic                  role,
    input  logic                  low_E,
    input  logic                  iHaveData,
    input  logic [5:0]            neighborCount,
    input  logic                  reward_done,
    input  logic                  tx_ready,
    output logic                  reward_en,
    output logic [2:0]            sched_type,
    output logic [5:0]            nTableIndex_sched,
    output logic                  tx_valid,
    output logic                  busy,
    output logic                  sched_err
);
    // Flag indices double as priority: lower index wins.
    localparam logic [2:0] F_SOS   = 3'd0;
    localparam logic [2:0] F_DATA  = 3'd1;
    localparam logic [2:0] F_HB    = 3'd2;
    localparam logic [2:0] F_INV   = 3'd3;
    localparam logic [2:0] F_CHINV = 3'd4;
    localparam logic [2:0] F_CHT   = 3'd5;
    localparam logic [2:0] F_MR    = 3'd6;
    localparam logic [2:0] F_OWN   = 3'd7;

    localparam logic [15:0]           MR_LOAD   = 16'(MR_TIMEOUT);
    localparam logic [15:0]           CHT_LOAD  = 16'(CHT_TIMEOUT);
    localparam logic [WORD_WIDTH-1:0] HOP_LIMIT = WORD_WIDTH'(MAX_INV_HOPS);
    localparam logic [7:0]            DONE_LAST = 8'(DONE_LIMIT - 1);

    typedef enum logic [1:0] {S_IDLE, S_LAUNCH, S_WAIT_DONE, S_TX} state_t;
    state_t state, state_nxt;

    logic [7:0]  flags, flag_set, flag_clr;
    logic [2:0]  grant_src, cur_src, type_q;
    logic        grant_any, cht_skip, launch, tx_done, cht_more, timeout;
    logic        hb_lock, role_q, inv_rx, own_busy;
    logic        mr_armed, mr_used, mr_expire, cht_armed, cht_expire;
    logic [15:0] mr_cnt, cht_cnt;
    logic [7:0]  done_cnt;
    logic        err_q;
    logic [5:0]  idx_q;

    function automatic logic [2:0] src_type(input logic [2:0] src);
        case (src)
            F_SOS:            return 3'b110;
            F_HB:             return 3'b000;
            F_INV, F_CHINV:   return 3'b010;
            F_CHT:            return 3'b100;
            F_MR:             return 3'b011;
            default:          return 3'b101;
        endcase
    endfunction

    assign inv_rx     = en && (fPacketType == 3'b010);
    assign own_busy   = (state != S_IDLE) && (cur_src == F_OWN);
    assign mr_expire  = mr_armed && (mr_cnt <= 16'd1);
    assign cht_expire = cht_armed && (cht_cnt <= 16'd1);

    always_comb begin
        grant_src = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (flags[i]) grant_src = 3'(i);
        end
    end

    assign grant_any = |flags;
    assign cht_skip  = (state == S_IDLE) && grant_any && (grant_src == F_CHT) && (neighborCount == 6'd0);
    assign launch    = (state == S_IDLE) && grant_any && !cht_skip;
    assign tx_done   = (state == S_TX) && tx_ready;
    assign cht_more  = (cur_src == F_CHT) && (({1'b0, idx_q} + 7'd1) < {1'b0, neighborCount});
    assign timeout   = (state == S_WAIT_DONE) && !reward_done && (done_cnt >= DONE_LAST);

    always_comb begin
        flag_set          = 8'd0;
        flag_set[F_SOS]   = en && iAmDestination && low_E;
        flag_set[F_DATA]  = en && (fPacketType == 3'b101) && iAmDestination && !low_E;
        flag_set[F_HB]    = en && (fPacketType == 3'b000) && !hb_lock;
        flag_set[F_INV]   = inv_rx && (hopsFromCH < HOP_LIMIT) && !role;
        flag_set[F_CHINV] = role && !role_q;
        flag_set[F_CHT]   = cht_expire;
        flag_set[F_MR]    = mr_expire;
        flag_set[F_OWN]   = iHaveData && !own_busy;
        flag_clr          = 8'd0;
        if (launch || cht_skip) flag_clr[grant_src] = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:      if (launch) state_nxt = S_LAUNCH;
            S_LAUNCH:    state_nxt = S_WAIT_DONE;
            S_WAIT_DONE: begin
                if (reward_done)  state_nxt = S_TX;
                else if (timeout) state_nxt = S_IDLE;
            end
            S_TX:        if (tx_ready) state_nxt = cht_more ? S_LAUNCH : S_IDLE;
            default:     state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        reward_en = (state == S_LAUNCH);
        tx_valid  = (state == S_TX);
        busy      = (state != S_IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            flags     <= 8'd0;
            role_q    <= 1'b0;
            hb_lock   <= 1'b0;
            mr_armed  <= 1'b0;
            mr_used   <= 1'b0;
            mr_cnt    <= 16'd0;
            cht_armed <= 1'b0;
            cht_cnt   <= 16'd0;
            done_cnt  <= 8'd0;
            err_q     <= 1'b0;
            cur_src   <= 3'd0;
            type_q    <= 3'b111;
            idx_q     <= 6'd32;
        end else begin
            // Set wins over the grant clear on the same edge.
            flags  <= (flags & ~flag_clr) | flag_set;
            role_q <= role;
            if (flag_set[F_HB])                     hb_lock <= 1'b1;
            else if (en && fPacketType == 3'b101)   hb_lock <= 1'b0;

            // MR timer arms once per reset on the first INV heard as a member.
            if (!mr_armed && !mr_used && inv_rx && !role) begin
                mr_armed <= 1'b1;
                mr_used  <= 1'b1;
                mr_cnt   <= MR_LOAD;
            end else if (mr_expire) begin
                mr_armed <= 1'b0;
                mr_cnt   <= 16'd0;
            end else if (mr_armed) begin
                mr_cnt   <= mr_cnt - 16'd1;
            end

            if (tx_done && cur_src == F_CHINV) begin
                cht_armed <= 1'b1;
                cht_cnt   <= CHT_LOAD;
            end else if (cht_expire) begin
                cht_armed <= 1'b0;
                cht_cnt   <= 16'd0;
            end else if (cht_armed) begin
                cht_cnt   <= cht_cnt - 16'd1;
            end

            if (state == S_LAUNCH)                           done_cnt <= 8'd0;
            else if (state == S_WAIT_DONE && !reward_done)  done_cnt <= done_cnt + 8'd1;
            err_q <= timeout;

            if (launch) begin
                cur_src <= grant_src;
                type_q  <= src_type(grant_src);
            end else if (timeout) begin
                type_q  <= 3'b111;
            end

            if (launch)                                        idx_q <= (grant_src == F_CHT) ? 6'd0 : 6'd32;
            else if (tx_done && cht_more)                      idx_q <= idx_q + 6'd1;
            else if (state != S_IDLE && state_nxt == S_IDLE)   idx_q <= 6'd32;
        end
    end

    assign sched_type        = type_q;
    assign nTableIndex_sched = idx_q;
    assign sched_err         = err_q;
endmodule

// File: tb/tb_packet_scheduler.sv
// tb/tb_packet_scheduler.sv - Directed table and sequence bench for packet_scheduler
module tb_packet_scheduler;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en = 1'b0;
    logic [2:0]  fPacketType = 3'b111;
    logic        iAmDestination = 1'b0;
    logic [15:0] hopsFromCH = 16'd0;
    logic        role = 1'b0;
    logic        low_E = 1'b0;
    logic        iHaveData = 1'b0;
    logic [5:0]  neighborCount = 6'd0;
    logic        reward_done = 1'b0;
    logic        tx_ready = 1'b0;
    logic        reward_en, tx_valid, busy, sched_err;
    logic [2:0]  sched_type;
    logic [5:0]  nTableIndex_sched;

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    packet_scheduler dut (
        .clk(clk), .rst(rst), .en(en), .fPacketType(fPacketType),
        .iAmDestination(iAmDestination), .hopsFromCH(hopsFromCH), .role(role),
        .low_E(low_E), .iHaveData(iHaveData), .neighborCount(neighborCount),
        .reward_done(reward_done), .tx_ready(tx_ready), .reward_en(reward_en),
        .sched_type(sched_type), .nTableIndex_sched(nTableIndex_sched),
        .tx_valid(tx_valid), .busy(busy), .sched_err(sched_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [2:0]  ptype;
        logic        dest;
        logic        lowe;
        logic [15:0] hops;
        logic        exp_launch;
        logic [2:0]  exp_type;
    } vec_t;

    vec_t vecs[10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
        cyc++;
    endtask

    task automatic reset_dut();
        en = 1'b0; reward_done = 1'b0; tx_ready = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic send_pkt(input logic [2:0] t, input logic d, input logic le, input logic [15:0] h);
        en = 1'b1; fPacketType = t; iAmDestination = d; low_E = le; hopsFromCH = h;
        tick();
        en = 1'b0; fPacketType = 3'b111; iAmDestination = 1'b0; low_E = 1'b0; hopsFromCH = 16'd0;
    endtask

    task automatic wait_launch(input int budget, output int n);
        n = 0;
        while (!reward_en && n < budget) begin
            tick();
            n++;
        end
        if (!reward_en) n = -1;
    endtask

    task automatic complete_txn(input string name);
        tick();
        reward_done = 1'b1;
        tick();
        reward_done = 1'b0;
        check({name, "_tx_valid"}, tx_valid, 1);
        tx_ready = 1'b1;
        tick();
        tx_ready = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int n;
        int c0;
        vecs[0] = '{"hb",          3'b000, 1'b0, 1'b0, 16'd0, 1'b1, 3'b000};
        vecs[1] = '{"sos",         3'b011, 1'b1, 1'b1, 16'd0, 1'b1, 3'b110};
        vecs[2] = '{"data_fwd",    3'b101, 1'b1, 1'b0, 16'd0, 1'b1, 3'b101};
        vecs[3] = '{"data_other",  3'b101, 1'b0, 1'b0, 16'd0, 1'b0, 3'b111};
        vecs[4] = '{"inv_hops3",   3'b010, 1'b0, 1'b0, 16'd3, 1'b1, 3'b010};
        vecs[5] = '{"inv_hops4",   3'b010, 1'b0, 1'b0, 16'd4, 1'b0, 3'b111};
        vecs[6] = '{"inv_hops0",   3'b010, 1'b0, 1'b0, 16'd0, 1'b1, 3'b010};
        vecs[7] = '{"sos_data",    3'b101, 1'b1, 1'b1, 16'd0, 1'b1, 3'b110};
        vecs[8] = '{"sos_over_hb", 3'b000, 1'b1, 1'b1, 16'd0, 1'b1, 3'b110};
        vecs[9] = '{"che_other",   3'b001, 1'b0, 1'b0, 16'd0, 1'b0, 3'b111};

        reset_dut();
        check("rst_reward_en", reward_en, 0);
        check("rst_tx_valid", tx_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_sched_err", sched_err, 0);
        check("rst_sched_type", sched_type, 3'b111);
        check("rst_index", nTableIndex_sched, 32);

        foreach (vecs[i]) begin
            reset_dut();
            send_pkt(vecs[i].ptype, vecs[i].dest, vecs[i].lowe, vecs[i].hops);
            tick();
            check({vecs[i].name, "_launch"}, reward_en, vecs[i].exp_launch);
            if (vecs[i].exp_launch) begin
                check({vecs[i].name, "_type"}, sched_type, vecs[i].exp_type);
                check({vecs[i].name, "_busy"}, busy, 1);
                complete_txn(vecs[i].name);
            end
            check({vecs[i].name, "_idle"}, busy, 0);
        end

        // Heartbeat lock: second HB ignored until a Data packet is seen.
        reset_dut();
        send_pkt(3'b000, 1'b0, 1'b0, 16'd0);
        tick();
        check("hb1_launch", reward_en, 1);
        tick();
        check("hb1_reward_en_one_cycle", reward_en, 0);
        reward_done = 1'b1;
        tick();
        reward_done = 1'b0;
        tick();
        check("hb1_tx_valid_held", tx_valid, 1);
        tx_ready = 1'b1;
        tick();
        tx_ready = 1'b0;
        check("hb1_tx_released", tx_valid, 0);
        send_pkt(3'b000, 1'b0, 1'b0, 16'd0);
        wait_launch(6, n);
        check("hb2_locked", n, -1);
        send_pkt(3'b101, 1'b0, 1'b0, 16'd0);
        send_pkt(3'b000, 1'b0, 1'b0, 16'd0);
        wait_launch(3, n);
        check("hb3_unlocked", n, 1);
        check("hb3_type", sched_type, 3'b000);

        // SOS and HB together: SOS first, HB launches right after IDLE return.
        reset_dut();
        send_pkt(3'b000, 1'b1, 1'b1, 16'd0);
        tick();
        check("sos_hb_first", sched_type, 3'b110);
        complete_txn("sos_hb_first");
        wait_launch(3, n);
        check("sos_hb_second_lat", n, 1);
        check("sos_hb_second_type", sched_type, 3'b000);

        // INV ripple then MR from the one-shot MR timer.
        reset_dut();
        c0 = cyc;
        send_pkt(3'b010, 1'b0, 1'b0, 16'd3);
        tick();
        check("inv3_type", sched_type, 3'b010);
        complete_txn("inv3");
        wait_launch(40, n);
        check("mr_launch", reward_en, 1);
        check("mr_latency", cyc - c0, 17);
        check("mr_type", sched_type, 3'b011);
        complete_txn("mr");
        wait_launch(40, n);
        check("mr_no_rearm", n, -1);

        reset_dut();
        c0 = cyc;
        send_pkt(3'b010, 1'b0, 1'b0, 16'd4);
        wait_launch(40, n);
        check("inv4_mr_latency", cyc - c0, 17);
        check("inv4_mr_type", sched_type, 3'b011);

        // Cluster head: INV, then CHT per neighbor after the CHT timer.
        role = 1'b0;
        reset_dut();
        neighborCount = 6'd3;
        c0 = cyc;
        role = 1'b1;
        tick();
        tick();
        check("chinv_type", sched_type, 3'b010);
        complete_txn("chinv");
        wait_launch(40, n);
        check("cht_latency", cyc - c0, 21);
        for (int k = 0; k < 3; k++) begin
            check($sformatf("cht%0d_launch", k), reward_en, 1);
            check($sformatf("cht%0d_type", k), sched_type, 3'b100);
            check($sformatf("cht%0d_index", k), nTableIndex_sched, k);
            complete_txn("cht");
        end
        check("cht_end_idle", busy, 0);
        check("cht_end_index", nTableIndex_sched, 32);

        role = 1'b0;
        reset_dut();
        neighborCount = 6'd0;
        role = 1'b1;
        tick();
        tick();
        check("chinv0_type", sched_type, 3'b010);
        complete_txn("chinv0");
        wait_launch(40, n);
        check("cht_none", n, -1);
        check("cht_none_index", nTableIndex_sched, 32);
        role = 1'b0;

        // Watchdog when reward_done never arrives.
        reset_dut();
        send_pkt(3'b000, 1'b0, 1'b0, 16'd0);
        tick();
        n = 0;
        while (!sched_err && n < 100) begin
            tick();
            n++;
        end
        check("wd_latency", n, 64);
        check("wd_idle", busy, 0);
        check("wd_type", sched_type, 3'b111);
        tick();
        check("wd_pulse_one_cycle", sched_err, 0);

        // Reset in the middle of TX abandons everything.
        reset_dut();
        send_pkt(3'b000, 1'b1, 1'b1, 16'd0);
        tick();
        tick();
        reward_done = 1'b1;
        tick();
        reward_done = 1'b0;
        check("rtx_in_tx", tx_valid, 1);
        rst = 1'b1;
        #1;
        check("rtx_tx_valid", tx_valid, 0);
        check("rtx_busy", busy, 0);
        check("rtx_type", sched_type, 3'b111);
        check("rtx_index", nTableIndex_sched, 32);
        @(negedge clk);
        rst = 1'b0;
        tick();
        check("rtx_post_idle", busy, 0);
        wait_launch(8, n);
        check("rtx_no_pending", n, -1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
